// File: rtl/seg_pkg.sv
// Shared types for the measurement/display path: unsigned aliases, BCD digit,
// converter FSM states and the hex-to-7-segment table.
package seg_pkg;

   typedef logic [5:0]  u6;
   typedef logic [27:0] u28;
   typedef logic [31:0] u32;
   typedef logic [3:0]  bcd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_e;

   // Segment order {g,f,e,d,c,b,a}, active high; entry 15 first.
   localparam logic [15:0][6:0] SEG7_TAB = {
      7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
      7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
   };

   function automatic logic [6:0] seg7(input bcd_t d);
      return SEG7_TAB[d];
   endfunction

endpackage

// File: rtl/bcd_arb_if.sv
// Request/result bundle between the measurement channels and the shared
// binary-to-BCD converter.
interface bcd_arb_if #(
   parameter int NCH = 4,
   parameter int W   = 28,
   parameter int ND  = 8
);
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]                req;
   logic [NCH-1:0][W-1:0]         val;
   logic [NCH-1:0]                ack;
   logic [NCH-1:0][ND-1:0][3:0]   bcd_q;
   logic [NCH-1:0]                ovf_q;
   logic                          busy;
   logic [GW-1:0]                 gnt;

   modport master (output req, val, input ack, bcd_q, ovf_q, busy, gnt);
   modport slave  (input req, val, output ack, bcd_q, ovf_q, busy, gnt);
endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble step over ND+1 BCD digits: add 3 to every digit >= 5,
// then shift the whole accumulator left by one, taking sin as the new LSB.
module bcd_dd_step
   import seg_pkg::*;
#(
   parameter int ND = 8
) (
   input  logic [(ND+1)*4-1:0] acc_in,
   input  logic                sin,
   output logic [(ND+1)*4-1:0] acc_out,
   output logic                cout
);

   logic [ND+1:0] carry;

   assign carry[0] = sin;
   assign cout     = carry[ND+1];

   genvar gi;
   generate
      for (gi = 0; gi < ND + 1; gi++) begin : g_dig
         bcd_t d;
         bcd_t a;
         assign d = acc_in[gi*4 +: 4];
         assign a = (d >= 4'd5) ? d + 4'd3 : d;
         assign acc_out[gi*4 +: 4] = {a[2:0], carry[gi]};
         assign carry[gi+1] = a[3];
      end
   endgenerate

endmodule

// File: rtl/bcd_arb.sv
// Round-robin arbiter in front of a serial double-dabble converter; results land
// in per-channel BCD registers. Define BCD_SAT_EN to saturate overflowing results to all 9s.
module bcd_arb
   import seg_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W   = 28,
   parameter int ND  = 8
) (
   input  logic      clk,
   input  logic      rst,
   bcd_arb_if.slave  bus
);

   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(W + 1);
   localparam int AW = (ND + 1) * 4;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SHIFT = SHIFT;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0]                   state_reg;
   logic [GW-1:0]                ptr_reg;
   logic [GW-1:0]                gnt_reg;
   logic [CW-1:0]                cnt_reg;
   logic [W-1:0]                 shift_reg;
   logic [AW-1:0]                acc_reg;
   logic [AW-1:0]                acc_next;
   logic                         spill_reg;
   logic                         spill_next;
   logic [NCH-1:0]               ack_reg;
   logic [NCH-1:0][ND-1:0][3:0]  bcd_reg;
   logic [NCH-1:0]               ovf_reg;

   logic [GW-1:0]                pick;
   logic                         pick_ok;
   logic                         ovf_now;
   logic [ND*4-1:0]              bcd_res;

   // Scan downwards so the requester closest to ptr (cyclically) wins last.
   always_comb begin : rr
      int            j;
      logic [GW-1:0] idx;
      j       = 0;
      idx     = '0;
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         j = int'(ptr_reg) + i;
         if (j >= NCH) j = j - NCH;
         idx = GW'(j);
         if (bus.req[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   bcd_dd_step #(.ND(ND)) u_step (
      .acc_in  (acc_reg),
      .sin     (shift_reg[W-1]),
      .acc_out (acc_next),
      .cout    (spill_next)
   );

   // A carry out of the top digit can only occur if W breaks its range limit;
   // it is folded into the overflow flag rather than silently dropped.
   assign ovf_now = (acc_reg[AW-1 -: 4] != 4'd0) | spill_reg;

`ifdef BCD_SAT_EN
   assign bcd_res = ovf_now ? {ND{4'h9}} : acc_reg[ND*4-1:0];
`else
   assign bcd_res = acc_reg[ND*4-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         ptr_reg   <= '0;
         gnt_reg   <= '0;
         cnt_reg   <= '0;
         shift_reg <= '0;
         acc_reg   <= '0;
         spill_reg <= 1'b0;
         ack_reg   <= '0;
         bcd_reg   <= '0;
         ovf_reg   <= '0;
      end else begin
         ack_reg <= '0;
         case (state_reg)
            S_IDLE: begin
               if (pick_ok) begin
                  shift_reg <= bus.val[pick];
                  acc_reg   <= '0;
                  spill_reg <= 1'b0;
                  cnt_reg   <= CW'(W);
                  gnt_reg   <= pick;
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc_reg   <= acc_next;
               spill_reg <= spill_reg | spill_next;
               shift_reg <= shift_reg << 1;
               cnt_reg   <= cnt_reg - 1'b1;
               if (cnt_reg == CW'(1)) state_reg <= S_DONE;
            end
            S_DONE: begin
               bcd_reg[gnt_reg] <= bcd_res;
               ovf_reg[gnt_reg] <= ovf_now;
               ack_reg[gnt_reg] <= 1'b1;
               ptr_reg   <= (gnt_reg == GW'(NCH - 1)) ? '0 : gnt_reg + 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.ack   = ack_reg;
   assign bus.bcd_q = bcd_reg;
   assign bus.ovf_q = ovf_reg;
   assign bus.busy  = (state_reg != S_IDLE);
   assign bus.gnt   = gnt_reg;

endmodule
